// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiply/divide unit producing the HI/LO pair.
// Define MULDIV_SIGNED_EN to enable signed MULT/DIV; otherwise they act as MULTU/DIVU.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_a;
    logic [31:0] r_rs_raw;
    logic        r_is_div;
    logic        r_dz;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_sgn;
    logic w_rs_neg;
    logic w_rt_neg;

    assign w_sgn    = ~op[0];
    assign w_rs_neg = w_sgn & rs_data[31];
    assign w_rt_neg = w_sgn & rt_data[31];
    assign w_rs_mag = w_rs_neg ? -rs_data : rs_data;
    assign w_rt_mag = w_rt_neg ? -rt_data : rt_data;
`else
    logic w_unused_op0;

    assign w_unused_op0 = op[0];
    assign w_rs_mag     = rs_data;
    assign w_rt_mag     = rt_data;
`endif

    // Shift-add step: multiplier sits in the low half and drains out the bottom.
    logic [32:0] w_add;
    logic [63:0] w_mul_nxt;

    assign w_add     = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_a : 32'd0)};
    assign w_mul_nxt = {w_add, r_acc[31:1]};

    // Restoring step: 33-bit trial subtract of the shifted remainder.
    logic [33:0] w_diff;
    logic        w_fit;
    logic [63:0] w_div_nxt;

    assign w_diff    = {1'b0, r_acc[63:31]} - {2'b00, r_a};
    assign w_fit     = ~w_diff[33];
    assign w_div_nxt = {(w_fit ? w_diff[31:0] : r_acc[62:31]), r_acc[30:0], w_fit};

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_prod = r_acc;
        w_quo  = r_acc[31:0];
        w_rem  = r_acc[63:32];
`ifdef MULDIV_SIGNED_EN
        if (r_neg_q) begin
            w_prod = -r_acc;
            w_quo  = -r_acc[31:0];
        end
        if (r_neg_r) begin
            w_rem = -r_acc[63:32];
        end
`endif
        if (!r_is_div) begin
            w_res_hi = w_prod[63:32];
            w_res_lo = w_prod[31:0];
        end else if (r_dz) begin
            w_res_hi = r_rs_raw;
            w_res_lo = 32'hFFFF_FFFF;
        end else begin
            w_res_hi = w_rem;
            w_res_lo = w_quo;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = op[1] ? S_DIV : S_MUL;
            S_MUL:  if (r_cnt == 6'd31) w_next = S_FIN;
            S_DIV:  if (r_cnt == 6'd31) w_next = S_FIN;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_a      <= 32'd0;
            r_rs_raw <= 32'd0;
            r_is_div <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= 6'd0;
                        r_a      <= op[1] ? w_rt_mag : w_rs_mag;
                        r_acc    <= {32'd0, (op[1] ? w_rs_mag : w_rt_mag)};
                        r_is_div <= op[1];
                        r_dz     <= (rt_data == 32'd0);
                        r_rs_raw <= rs_data;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q  <= w_rs_neg ^ w_rt_neg;
                        r_neg_r  <= w_rs_neg;
`endif
                    end else begin
                        if (wr_hi) r_hi <= wr_data;
                        if (wr_lo) r_lo <= wr_data;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DIV: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIN: begin
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                    r_done <= 1'b1;
                    r_cnt  <= 6'd0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: arithmetic reference model, per-cycle compare, directed cases.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wr_data = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    mul_div_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [63:0] ref_res(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic sgn;
        int   q;
        int   r;
`ifdef MULDIV_SIGNED_EN
        sgn = !o[0];
`else
        sgn = 1'b0;
`endif
        if (!o[1]) begin
            if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
            return 64'(a) * 64'(b);
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: a countdown of the 33 busy cycles and the pending result.
    int          m_cnt;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                m_cnt <= 33;
                {p_hi, p_lo} <= ref_res(op, rs_data, rt_data);
            end else begin
                if (wr_hi) m_hi <= wr_data;
                if (wr_lo) m_lo <= wr_data;
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_done));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    task automatic wait_done(input string nm, input int lat,
                             input logic [31:0] eh, input logic [31:0] el);
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: done=%b required 1", nm, done);
        end else begin
            chk({nm, "_lat"}, 32'(k), 32'(lat));
            chk({nm, "_hi"}, hi, eh);
            chk({nm, "_lo"}, lo, el);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom % 6)
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk_en = 1'b1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
`ifdef MULDIV_SIGNED_EN
        wait_done("mult_m3x5", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`else
        wait_done("mult_m3x5", 33, 32'h0000_0004, 32'hFFFF_FFF1);
`endif

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_SIGNED_EN
        wait_done("div_m7d2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        wait_done("div_m7d2", 33, 32'h0000_0001, 32'h7FFF_FFFC);
`endif

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
`ifdef MULDIV_SIGNED_EN
        wait_done("div_ovf", 33, 32'h0000_0000, 32'h8000_0000);
`else
        wait_done("div_ovf", 33, 32'h8000_0000, 32'h0000_0000);
`endif

        issue(2'b11, 32'd7, 32'd0);
        wait_done("divu_dz", 33, 32'h0000_0007, 32'hFFFF_FFFF);

        issue(2'b11, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start   = 1'b1;
        op      = 2'b01;
        rs_data = 32'd5;
        rt_data = 32'd6;
        wr_hi   = 1'b1;
        wr_data = 32'hAAAA_5555;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        wait_done("divu_intf", 23, 32'd2, 32'd14);
        wr_lo   = 1'b1;
        wr_data = 32'h0000_1234;
        @(negedge clk);
        wr_lo = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_1234);
        chk("mtlo_hi", hi, 32'd2);

        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (16) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(2'b01, 32'd3, 32'd4);
        wait_done("multu_3x4", 33, 32'd0, 32'd12);

        start   = 1'b1;
        op      = 2'b01;
        rs_data = 32'd2;
        rt_data = 32'd3;
        wr_hi   = 1'b1;
        wr_data = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b0;
        wait_done("start_wins", 33, 32'd0, 32'd6);

        for (int i = 0; i < 3000; i++) begin
            start   = (($urandom % 4) == 0);
            op      = 2'($urandom);
            rs_data = rnd_word();
            rt_data = rnd_word();
            wr_hi   = (($urandom % 8) == 0);
            wr_lo   = (($urandom % 8) == 0);
            wr_data = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit producing the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the execute path and consumes the two register-file read ports (rs/rt data). The control unit stalls the PC on `busy` and reads results through MFHI/MFLO from `hi`/`lo`. Each operation runs 32 cycles with a start/busy/done handshake.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin the operation selected by `op`; sampled only when idle
- op  in  2  operation code, equal to funct[1:0]: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  32  multiplicand / dividend
- rt_data  in  32  multiplier / divisor
- wr_hi  in  1  MTHI: load `wr_data` into HI
- wr_lo  in  1  MTLO: load `wr_data` into LO
- wr_data  in  32  MTHI/MTLO source data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; HI/LO are valid in this cycle
- hi  out  32  HI register
- lo  out  32  LO register

Clock and reset are fixed: one clock `clk`; `rst` is asynchronous and active-high.

## Operation
- FSM states: IDLE, MUL, DIV, FIN. Reset value is IDLE.
- Reset values: hi=0, lo=0, busy=0, done=0, 6-bit iteration counter=0.
- IDLE with start=1:
  - Latch the operands, as magnitudes for signed ops.
  - Record the result signs.
  - Clear the accumulator.
  - Go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: radix-2 shift-add over a 64-bit product, one multiplier bit per cycle, 32 iterations.
- DIV: restoring division, 64-bit remainder/quotient shift register, one quotient bit per cycle, 32 iterations.
- FIN:
  - Apply sign correction.
  - Write HI/LO.
  - Assert done for one cycle.
  - Return to IDLE.
- Multiply results: HI = product[63:32], LO = product[31:0].
- Divide results: LO = quotient, HI = remainder.
- Signed sign rules:
  - Product sign = sign(rs) XOR sign(rt); the 64-bit product is negated as a unit.
  - Quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divide by zero, signed or unsigned:
  - HI = rs_data as issued, LO = 0xFFFFFFFF.
  - No sign correction.
  - Same latency as a normal divide.
- Ignored inputs:
  - start while busy: ignored; the operation in flight is unaffected.
  - wr_hi/wr_lo while busy or in FIN: ignored.
- MTHI/MTLO while IDLE:
  - The write takes effect at the next edge.
  - wr_hi and wr_lo together write both registers.
- start and wr_hi/wr_lo in the same idle cycle: start wins, the write is dropped.
- HI/LO change only at FIN, on an accepted MTHI/MTLO write, or on reset.

## Timing
- Issue: start is sampled at edge E0 (IDLE). busy=1 from E0 through E33 (33 cycles), so the PC stalls on the instruction after issue.
- Iterations: edges E1..E32.
- Completion: the FIN edge E33 writes HI/LO. done=1 and busy=0 for the cycle following E33.
- Back-to-back: a new start is accepted in the same cycle done is high.
- Operand capture: rs_data/rt_data are sampled only at E0 and may change afterwards.
- Reset mid-operation, asynchronous:
  - State goes to IDLE immediately.
  - busy and done go to 0; hi and lo go to 0.
  - The partial result is discarded.

## Configuration
- MULDIV_SIGNED_EN
  - Defined: MULT/DIV perform two's-complement signed arithmetic as specified above.
  - Undefined: op[0] is ignored. MULT behaves as MULTU and DIV as DIVU. Sign-correction logic is not synthesized.
  - Latency is identical either way.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles done pulses; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (−3) × 5:
  - With MULDIV_SIGNED_EN: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - Without it: HI=0x00000004, LO=0xFFFFFFF1.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 7 / 0 → HI=0x00000007, LO=0xFFFFFFFF, done at the normal latency.
- Busy-cycle interference:
  - Start DIVU 100/7; at cycle 10 pulse start with other operands and pulse wr_hi=0xAAAA5555.
  - Required: both ignored; HI=2, LO=14 at done.
  - Then, idle: wr_lo=0x1234 → LO=0x1234 at the next edge, HI unchanged.
- Reset mid-operation: assert rst at iteration 16 of MULTU → busy, done, HI, LO all 0 immediately. After release, a fresh MULTU 3×4 gives LO=12, HI=0.
